// File: rtl/safe_pkg.sv
// rtl/safe_pkg.sv - shared cracker state encoding, width helpers and default safe timing
package safe_pkg;

    localparam int DEF_WIDTH        = 10;
    localparam int DEF_HINT_LAT     = 2;
    localparam int DEF_ENTER_CYCLES = 4;
    localparam int DEF_TIMEOUT      = 16;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_BASE    = 4'd1,
        ST_FLIP    = 4'd2,
        ST_SETTLE  = 4'd3,
        ST_DECIDE  = 4'd4,
        ST_SUBMIT  = 4'd5,
        ST_CONFIRM = 4'd6,
        ST_DONE    = 4'd7,
        ST_FAIL    = 4'd8
    } cracker_state_t;

    // Width of the safe's Hamming-distance hint for a given password width
    function automatic int hint_w(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cracker_timer.sv
// rtl/cracker_timer.sv - loadable down-counter with zero flag for cracker phase durations
module cracker_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    // Load on phase entry, then count down and park at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/safe_cracker.sv
// rtl/safe_cracker.sv - one-probe-per-bit password recovery agent; CRACKER_EARLY_EXIT_EN enables early submit
module safe_cracker
    import safe_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int HINT_LAT     = DEF_HINT_LAT,
    parameter int ENTER_CYCLES = DEF_ENTER_CYCLES,
    parameter int TIMEOUT      = DEF_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          RESETN,
    input  logic                          start,
    input  logic [hint_w(WIDTH)-1:0]      hint,
    input  logic                          LOCKED,
    output logic [WIDTH-1:0]              guess,
    output logic                          ENTER,
    output logic                          busy,
    output logic                          done,
    output logic                          fail,
    output logic [$clog2(WIDTH+2)-1:0]    probes
);

    localparam int HW   = hint_w(WIDTH);
    localparam int PW   = $clog2(WIDTH + 2);
    localparam int IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int TMAX = max3(HINT_LAT, ENTER_CYCLES, TIMEOUT);
    localparam int TW   = $clog2(TMAX + 1);

    // Timer counts load_val..0 inclusive, so each phase loads its length minus one
    localparam logic [TW-1:0] T_HINT  = TW'(HINT_LAT - 1);
    localparam logic [TW-1:0] T_ENTER = TW'(ENTER_CYCLES - 1);
    localparam logic [TW-1:0] T_TMO   = TW'(TIMEOUT - 1);

`ifdef CRACKER_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    cracker_state_t  state, state_nxt;
    logic            tmr_load;
    logic [TW-1:0]   tmr_val;
    logic            tmr_zero;
    logic [IW-1:0]   idx;
    logic [HW-1:0]   base;
    logic [WIDTH-1:0] flip_mask;
    logic            hint_zero;
    logic            dist_dn;
    logic            dist_up;
    logic            last_bit;
    logic            solved;

    cracker_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (RESETN),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    assign flip_mask = WIDTH'(1) << idx;
    assign hint_zero = ~|hint;
    // A flip that helps drops distance by one; base==0 can never drop further
    assign dist_dn   = (base != '0) && (base - HW'(1) == hint);
    assign dist_up   = ({1'b0, hint} == ({1'b0, base} + (HW+1)'(1)));
    assign last_bit  = (idx == IW'(WIDTH - 1));
    assign solved    = dist_dn && hint_zero;

    // State register
    always_ff @(posedge clk or negedge RESETN) begin
        if (!RESETN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and timer loading on phase entry
    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        case (state)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (start) begin
                    state_nxt = ST_BASE;
                    tmr_load  = 1'b1;
                    tmr_val   = T_HINT;
                end
            end
            ST_BASE: begin
                if (tmr_zero) begin
                    if (EARLY_EXIT && hint_zero) begin
                        state_nxt = ST_SUBMIT;
                        tmr_load  = 1'b1;
                        tmr_val   = T_ENTER;
                    end else begin
                        state_nxt = ST_FLIP;
                    end
                end
            end
            ST_FLIP: begin
                state_nxt = ST_SETTLE;
                tmr_load  = 1'b1;
                tmr_val   = T_HINT;
            end
            ST_SETTLE: begin
                if (tmr_zero) begin
                    state_nxt = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                if (!(dist_dn || dist_up)) begin
                    state_nxt = ST_FAIL;
                end else if (last_bit || (EARLY_EXIT && solved)) begin
                    state_nxt = ST_SUBMIT;
                    tmr_load  = 1'b1;
                    tmr_val   = T_ENTER;
                end else begin
                    state_nxt = ST_FLIP;
                end
            end
            ST_SUBMIT: begin
                if (tmr_zero) begin
                    state_nxt = ST_CONFIRM;
                    tmr_load  = 1'b1;
                    tmr_val   = T_TMO;
                end
            end
            ST_CONFIRM: begin
                if (!LOCKED) begin
                    state_nxt = ST_DONE;
                end else if (tmr_zero) begin
                    state_nxt = ST_FAIL;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Moore outputs; ENTER follows state so reset drops it without waiting for a clock
    always_comb begin
        ENTER = (state == ST_SUBMIT);
        done  = (state == ST_DONE);
        fail  = (state == ST_FAIL);
        busy  = (state == ST_BASE)   || (state == ST_FLIP)   || (state == ST_SETTLE) ||
                (state == ST_DECIDE) || (state == ST_SUBMIT) || (state == ST_CONFIRM);
    end

    // Guess, bit index, baseline distance and probe count
    always_ff @(posedge clk or negedge RESETN) begin
        if (!RESETN) begin
            guess  <= '0;
            idx    <= '0;
            base   <= '0;
            probes <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (start) begin
                        guess  <= '0;
                        idx    <= '0;
                        base   <= '0;
                        probes <= '0;
                    end
                end
                ST_BASE: begin
                    if (tmr_zero) begin
                        base   <= hint;
                        probes <= probes + PW'(1);
                    end
                end
                ST_FLIP: begin
                    guess <= guess ^ flip_mask;
                end
                ST_DECIDE: begin
                    probes <= probes + PW'(1);
                    if (dist_dn) begin
                        base <= hint;
                    end else if (dist_up) begin
                        guess <= guess ^ flip_mask;
                    end
                    if (dist_dn || dist_up) begin
                        idx <= idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
